// File: rtl/seg_capture_pkg.sv
// seg_capture shared types: FSM states, seven-segment decode table,
// illegal-strobe mask and small strobe helpers.
package seg_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } state_t;

  // abcdefg active high, entry k decodes to nibble k
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h47, 7'h4F, 7'h3D, 7'h4E,
    7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33,
    7'h79, 7'h6D, 7'h30, 7'h7E
  };

  localparam logic [7:0] ILLEGAL_MASK = 8'hF0;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    return {v[3] | v[2], v[3] | v[1]};
  endfunction

endpackage

// File: rtl/seg_capture_decode.sv
// seg_decode: active-low abcdefg pattern to hex nibble plus hit flag.
// Purely combinational table lookup.
module seg_decode
  import seg_capture_pkg::*;
(
  input  logic [6:0] i_segN,
  output logic [3:0] o_nib,
  output logic       o_hit
);

  logic [6:0] w_pat;

  assign w_pat = ~i_segN;

  always_comb begin
    o_nib = 4'd0;
    o_hit = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (w_pat == SEG_TABLE[k]) begin
        o_nib = 4'(k);
        o_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_capture.sv
// seg_capture: rebuilds the 4-digit hex value and dots from a multiplexed
// active-low seven-segment scan. Dot capture enabled by SEG_CAPTURE_DOTS_EN.
module seg_capture
  import seg_capture_pkg::*;
#(
  parameter int STABLE_CYC = 4,
  parameter int TIMEOUT    = 1_000_000
) (
  input  logic        clk5,
  input  logic        reset,
  input  logic [7:0]  digit,
  input  logic [7:0]  segment,
  input  logic        errClr,
  output logic [15:0] capVal,
  output logic [3:0]  dots,
  output logic        frameValid,
  output logic        patErr,
  output logic        multiErr,
  output logic        stale
);

  localparam logic [7:0]  SC    = 8'(STABLE_CYC);
  localparam logic [7:0]  SC_M1 = 8'(STABLE_CYC - 1);
  localparam logic [23:0] TMO   = 24'(TIMEOUT);

  logic [7:0]  r_dR;
  logic [7:0]  r_sR;
  logic        r_chg;
  logic [7:0]  r_cnt;
  state_t      r_state;
  logic [3:0]  r_seen;
  logic [15:0] r_shadow;
  logic [15:0] r_cap;
  logic        r_fv;
  logic        r_pat;
  logic        r_multi;
  logic [23:0] r_tcnt;
  logic        r_stale;

  logic [7:0]  w_segIn;
  logic        w_new;
  logic        w_upper;
  logic        w_valid;
  logic        w_blank;
  logic        w_hit;
  logic        w_acc;
  logic        w_ill;
  logic        w_done;
  logic [1:0]  w_idx;
  logic [3:0]  w_nib;
  logic        w_dhit;
  logic [23:0] w_tnxt;
  state_t      w_nst;

`ifdef SEG_CAPTURE_DOTS_EN
  assign w_segIn = segment;
`else
  // dp is forced inactive so it cannot disturb the stability check
  assign w_segIn = {segment[7:1], 1'b1 | segment[0]};
`endif

  assign w_new   = {digit, w_segIn} != {r_dR, r_sR};
  assign w_upper = |(~r_dR & ILLEGAL_MASK);
  assign w_valid = !w_upper && is_onehot4(~r_dR[3:0]);
  assign w_blank = r_dR == 8'hFF;
  assign w_hit   = r_cnt == SC_M1;
  assign w_acc   = (r_state == ST_SETTLE) && w_hit;
  assign w_ill   = w_hit && !w_blank && !w_valid;
  assign w_done  = r_seen == 4'hF;
  assign w_idx   = onehot_idx(~r_dR[3:0]);

  seg_decode u_dec (
    .i_segN (r_sR[7:1]),
    .o_nib  (w_nib),
    .o_hit  (w_dhit)
  );

  always_comb begin
    w_nst = r_state;
    if (r_chg)
      w_nst = w_valid ? ST_SETTLE : ST_IDLE;
    else if (w_acc)
      w_nst = ST_HELD;
  end

  always_comb begin
    w_tnxt = r_tcnt;
    if (w_done)
      w_tnxt = 24'd0;
    else if (r_tcnt != TMO)
      w_tnxt = r_tcnt + 24'd1;
  end

  always_ff @(posedge clk5) begin
    if (reset) begin
      r_dR     <= 8'hFF;
      r_sR     <= 8'hFF;
      r_chg    <= 1'b0;
      r_cnt    <= 8'd0;
      r_state  <= ST_IDLE;
      r_seen   <= 4'd0;
      r_shadow <= 16'd0;
      r_cap    <= 16'd0;
      r_fv     <= 1'b0;
      r_pat    <= 1'b0;
      r_multi  <= 1'b0;
      r_tcnt   <= 24'd0;
      r_stale  <= 1'b1;
    end else begin
      r_dR    <= digit;
      r_sR    <= w_segIn;
      r_chg   <= w_new;
      r_state <= w_nst;
      if (w_new)
        r_cnt <= 8'd0;
      else if (r_cnt != SC)
        r_cnt <= r_cnt + 8'd1;
      if (w_done)
        r_seen <= 4'd0;
      else if (w_acc && w_dhit)
        r_seen[w_idx] <= 1'b1;
      if (w_acc && w_dhit)
        r_shadow[{w_idx, 2'b00} +: 4] <= w_nib;
      r_fv <= w_done;
      if (w_done)
        r_cap <= r_shadow;
      r_pat   <= (r_pat & ~errClr) | (w_acc & ~w_dhit);
      r_multi <= (r_multi & ~errClr) | w_ill;
      r_tcnt  <= w_tnxt;
      r_stale <= !w_done && (r_stale || w_tnxt == TMO);
    end
  end

`ifdef SEG_CAPTURE_DOTS_EN
  logic [3:0] r_sdot;
  logic [3:0] r_dots;

  always_ff @(posedge clk5) begin
    if (reset) begin
      r_sdot <= 4'd0;
      r_dots <= 4'd0;
    end else begin
      if (w_acc && w_dhit)
        r_sdot[w_idx] <= ~r_sR[0];
      if (w_done)
        r_dots <= r_sdot;
    end
  end

  assign dots = r_dots;
`else
  assign dots = 4'b0000;
`endif

  assign capVal     = r_cap;
  assign frameValid = r_fv;
  assign patErr     = r_pat;
  assign multiErr   = r_multi;
  assign stale      = r_stale;

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture with STABLE_CYC=4, TIMEOUT=100.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_seg_capture;

  logic        clk5 = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  digit = 8'hFF;
  logic [7:0]  segment = 8'hFF;
  logic        errClr = 1'b0;
  logic [15:0] capVal;
  logic [3:0]  dots;
  logic        frameValid;
  logic        patErr;
  logic        multiErr;
  logic        stale;

  int total = 0;
  int bad = 0;
  int fvCnt = 0;

  seg_capture #(.STABLE_CYC(4), .TIMEOUT(100)) dut (
    .clk5       (clk5),
    .reset      (reset),
    .digit      (digit),
    .segment    (segment),
    .errClr     (errClr),
    .capVal     (capVal),
    .dots       (dots),
    .frameValid (frameValid),
    .patErr     (patErr),
    .multiErr   (multiErr),
    .stale      (stale)
  );

  always #100 clk5 = ~clk5;

  always @(posedge clk5) if (frameValid) fvCnt <= fvCnt + 1;

  function automatic logic [7:0] seg(input logic [3:0] h, input logic dp);
    logic [6:0] t;
    case (h)
      4'h0: t = 7'h7E; 4'h1: t = 7'h30; 4'h2: t = 7'h6D; 4'h3: t = 7'h79;
      4'h4: t = 7'h33; 4'h5: t = 7'h5B; 4'h6: t = 7'h5F; 4'h7: t = 7'h70;
      4'h8: t = 7'h7F; 4'h9: t = 7'h7B; 4'hA: t = 7'h77; 4'hB: t = 7'h1F;
      4'hC: t = 7'h4E; 4'hD: t = 7'h3D; 4'hE: t = 7'h4F; default: t = 7'h47;
    endcase
    return ~{t, dp};
  endfunction

  function automatic logic [7:0] dsel(input int i);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << i);
  endfunction

  task automatic put(input logic [7:0] d, input logic [7:0] s, input int n);
    digit = d;
    segment = s;
    repeat (n) @(negedge clk5);
  endtask

  task automatic scan(input logic [15:0] v, input logic [3:0] dp, input int n);
    for (int i = 0; i < 4; i++)
      put(dsel(i), seg(v[i*4 +: 4], dp[i]), n);
    put(8'hFF, 8'hFF, 3);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    digit = 8'hFF;
    segment = 8'hFF;
    repeat (3) @(negedge clk5);
    reset = 1'b0;
    @(negedge clk5);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (capVal !== 16'h0) begin bad++; $display("FAIL rst_capVal got %h want 0000", capVal); end
    total++; if (dots !== 4'h0) begin bad++; $display("FAIL rst_dots got %b want 0000", dots); end
    total++; if (frameValid !== 1'b0) begin bad++; $display("FAIL rst_fv got %b want 0", frameValid); end
    total++; if (patErr !== 1'b0) begin bad++; $display("FAIL rst_patErr got %b want 0", patErr); end
    total++; if (multiErr !== 1'b0) begin bad++; $display("FAIL rst_multiErr got %b want 0", multiErr); end
    total++; if (stale !== 1'b1) begin bad++; $display("FAIL rst_stale got %b want 1", stale); end
  endtask

  task automatic test_frame();
    int c0;
    logic [7:0] obs;
    logic [15:0] v;
    v = 16'h1A3F;
    c0 = fvCnt;
    for (int i = 0; i < 3; i++)
      put(dsel(i), seg(v[i*4 +: 4], 1'b0), 8);
    digit = dsel(3);
    segment = seg(v[15:12], 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk5);
      obs[k] = frameValid;
    end
    put(8'hFF, 8'hFF, 3);
    total++; if (obs !== 8'b0010_0000) begin bad++; $display("FAIL frame_latency got %b want 00100000", obs); end
    total++; if (fvCnt - c0 !== 1) begin bad++; $display("FAIL frame_pulses got %0d want 1", fvCnt - c0); end
    total++; if (capVal !== 16'h1A3F) begin bad++; $display("FAIL frame_capVal got %h want 1a3f", capVal); end
    total++; if (stale !== 1'b0) begin bad++; $display("FAIL frame_stale got %b want 0", stale); end
    total++; if ({patErr, multiErr} !== 2'b00) begin bad++; $display("FAIL frame_errs got %b want 00", {patErr, multiErr}); end
  endtask

  task automatic test_ghost();
    int c0;
    c0 = fvCnt;
    scan(16'h5678, 4'b0000, 3);
    total++; if (fvCnt - c0 !== 0) begin bad++; $display("FAIL ghost_pulses got %0d want 0", fvCnt - c0); end
    total++; if (capVal !== 16'h1A3F) begin bad++; $display("FAIL ghost_capVal got %h want 1a3f", capVal); end
    total++; if ({patErr, multiErr} !== 2'b00) begin bad++; $display("FAIL ghost_errs got %b want 00", {patErr, multiErr}); end
  endtask

  task automatic test_badpat();
    int c0;
    c0 = fvCnt;
    put(dsel(1), 8'b0111_1111, 8);
    put(8'hFF, 8'hFF, 2);
    total++; if (patErr !== 1'b1) begin bad++; $display("FAIL badpat_set got %b want 1", patErr); end
    total++; if (fvCnt - c0 !== 0) begin bad++; $display("FAIL badpat_pulses got %0d want 0", fvCnt - c0); end
    errClr = 1'b1;
    @(negedge clk5);
    errClr = 1'b0;
    @(negedge clk5);
    total++; if (patErr !== 1'b0) begin bad++; $display("FAIL badpat_clr got %b want 0", patErr); end
  endtask

  task automatic test_multi();
    put(8'hFC, seg(4'h8, 1'b1), 8);
    put(8'hFF, 8'hFF, 2);
    total++; if (multiErr !== 1'b1) begin bad++; $display("FAIL multi_two got %b want 1", multiErr); end
    total++; if (patErr !== 1'b0) begin bad++; $display("FAIL multi_nodecode got %b want 0", patErr); end
    errClr = 1'b1;
    @(negedge clk5);
    errClr = 1'b0;
    @(negedge clk5);
    total++; if (multiErr !== 1'b0) begin bad++; $display("FAIL multi_clr got %b want 0", multiErr); end
    put(8'hEF, seg(4'h8, 1'b1), 8);
    put(8'hFF, 8'hFF, 2);
    total++; if (multiErr !== 1'b1) begin bad++; $display("FAIL multi_upper got %b want 1", multiErr); end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    for (int i = 0; i < 3; i++)
      put(dsel(i), seg(4'(i + 7), 1'b0), 8);
    digit = dsel(3);
    segment = seg(4'hA, 1'b0);
    n = 0;
    do begin
      @(negedge clk5);
      n++;
    end while (frameValid !== 1'b1 && n < 20);
    total++; if (frameValid !== 1'b1) begin bad++; $display("FAIL tmo_frame got %b want 1 within 20 cycles", frameValid); end
    total++; if (stale !== 1'b0) begin bad++; $display("FAIL tmo_clear got %b want 0", stale); end
    total++; if (capVal !== 16'hA987) begin bad++; $display("FAIL tmo_capVal got %h want a987", capVal); end
    digit = 8'hFF;
    segment = 8'hFF;
    repeat (99) @(negedge clk5);
    total++; if (stale !== 1'b0) begin bad++; $display("FAIL tmo_99 got %b want 0", stale); end
    @(negedge clk5);
    total++; if (stale !== 1'b1) begin bad++; $display("FAIL tmo_100 got %b want 1", stale); end
  endtask

  task automatic test_reset_mid();
    int c0;
    do_reset();
    c0 = fvCnt;
    put(dsel(0), seg(4'h1, 1'b0), 8);
    put(dsel(1), seg(4'h2, 1'b0), 8);
    put(8'hFF, 8'hFF, 2);
    do_reset();
    put(dsel(2), seg(4'h3, 1'b0), 8);
    put(dsel(3), seg(4'h4, 1'b0), 8);
    put(8'hFF, 8'hFF, 3);
    total++; if (fvCnt - c0 !== 0) begin bad++; $display("FAIL rstmid_pulses got %0d want 0", fvCnt - c0); end
    total++; if (capVal !== 16'h0) begin bad++; $display("FAIL rstmid_capVal got %h want 0000", capVal); end
    put(dsel(1), seg(4'h2, 1'b0), 8);
    put(dsel(0), seg(4'h1, 1'b0), 8);
    put(8'hFF, 8'hFF, 3);
    total++; if (fvCnt - c0 !== 1) begin bad++; $display("FAIL rstmid_done got %0d want 1", fvCnt - c0); end
    total++; if (capVal !== 16'h4321) begin bad++; $display("FAIL rstmid_val got %h want 4321", capVal); end
  endtask

  task automatic test_dots();
    logic [3:0] exp_d;
`ifdef SEG_CAPTURE_DOTS_EN
    exp_d = 4'b0100;
`else
    exp_d = 4'b0000;
`endif
    scan(16'hC0DE, 4'b0100, 8);
    total++; if (capVal !== 16'hC0DE) begin bad++; $display("FAIL dots_capVal got %h want c0de", capVal); end
    total++; if (dots !== exp_d) begin bad++; $display("FAIL dots_val got %b want %b", dots, exp_d); end
    total++; if (patErr !== 1'b0) begin bad++; $display("FAIL dots_patErr got %b want 0", patErr); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_ghost();
    test_badpat();
    test_multi();
    test_timeout();
    test_reset_mid();
    test_dots();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_capture.md
# seg_capture

Display capture block: the receiving end of the 4-digit multiplexed seven-segment interface. It watches the active-low `digit`/`segment` bus that the display interface drives and rebuilds the displayed 16-bit hex value and the 4 dot states from the multiplexed scan. It runs on the 5 MHz system clock and sits on the test hardware next to the display interface. Its job is automatic self-checking: the captured value can be compared against the value sent to the display.

## Interface
- `STABLE_CYC`, default 4: consecutive identical samples required before a strobe is accepted (2..255).
- `TIMEOUT`, default 1_000_000: cycles without a completed frame before `stale` asserts (200 ms at 5 MHz); 24-bit counter.
- `clk5`  in  1  5 MHz clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `digit`  in  8  digit enables, active low; bit 7 is leftmost. Only bits 3:0 are legal.
- `segment`  in  8  segment controls, active low, order a b c d e f g p (bit 7 = a, bit 0 = p).
- `errClr`  in  1  clears `patErr` and `multiErr`.
- `capVal`  out  16  last complete captured value; digit 3 maps to [15:12].
- `dots`  out  4  last captured dot states, active high.
- `frameValid`  out  1  one-cycle pulse when `capVal` and `dots` update.
- `patErr`  out  1  sticky flag: an accepted strobe carried a pattern not in the decode table.
- `multiErr`  out  1  sticky flag: a stable sample had more than one digit low, or any of `digit[7:4]` low.
- `stale`  out  1  no frame completed in the last `TIMEOUT` cycles.

## Operation
- Input registers: `digit` and `segment` are registered every cycle into `dR`/`sR`. All checks use these registered values.
- Stability counter: reset to 0 when {dR,sR} differs from its previous value; otherwise increments, saturating at STABLE_CYC.
- FSM (3 states):
  - IDLE: no single-digit strobe. Go to SETTLE when dR has exactly one of bits 3:0 low and bits 7:4 all high.
  - SETTLE: counting. When the stability count reaches STABLE_CYC, the strobe is accepted and the FSM goes to HELD. Any change of {dR,sR} returns to IDLE, or restarts SETTLE if the new sample is also a valid strobe.
  - HELD: already accepted; waits for {dR,sR} to change. This ensures one acceptance per strobe period.
- Blank samples (`dR` = 8'hFF) go to IDLE and are ignored with no error.
- Acceptance of digit i:
  - Decode `~sR[7:1]` through the hex table: 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47 (abcdefg, active high).
  - On a hit: write the nibble into shadow[i], write the dot (~sR[0]) into shadowDot[i], and set seen[i].
  - On a miss: set `patErr`; seen[i] is unchanged.
- Frame completion: when seen becomes 4'b1111, on the next edge `capVal`←shadow, `dots`←shadowDot, `frameValid`=1, seen←0. Scan order and repeated strobes do not matter; a later strobe of the same digit overwrites its shadow entry.
- Illegal strobe: a sample stable for STABLE_CYC cycles with more than one digit low, or any upper digit low, sets `multiErr` and is not decoded.
- Error clear: `errClr` clears both error flags. If `errClr` and a new error occur in the same cycle, the flag is set.
- Timeout counter:
  - Cleared by `frameValid`; otherwise increments, saturating at TIMEOUT.
  - `stale`=1 while the count equals TIMEOUT, and clears in the same edge that asserts `frameValid`.

## Timing
- Reset values:
  - `capVal`=0, `dots`=0, `frameValid`=0, `patErr`=0, `multiErr`=0.
  - `stale`=1 (no frame seen yet).
  - Internals: seen=0, shadow=0, timeout count=0, FSM=IDLE.
- A port value that first appears before edge t0 is accepted at edge t0+STABLE_CYC.
- If that acceptance completes the frame, `capVal`/`frameValid` update at t0+STABLE_CYC+1.
- Minimum digit dwell for capture is STABLE_CYC+1 cycles.
- Reset mid-frame: partial shadow and seen are discarded; the next frame needs all 4 digits again.

## Configuration
- `SEG_CAPTURE_DOTS_EN` defined: dots are captured and reported as described above.
- Not defined:
  - `segment[0]` is ignored; shadowDot logic is removed.
  - `dots` is tied to 4'b0000.
  - The decode table still ignores p, so patterns are accepted whatever the dp state.

## Structure
- Package `seg_capture_pkg`: the FSM state enum, the 16-entry 7-bit decode table constant, and a localparam for the illegal-strobe mask (8'hF0).
- One sub-module, `seg_decode`: 7-bit active-low pattern in, 4-bit nibble plus hit flag out. Purely combinational; used once.

## Test plan
- Normal frame: scan digits 0..3 of 16'h1A3F with 8-cycle dwell and STABLE_CYC=4 -> `frameValid` pulses once, `capVal`=16'h1A3F.
- Ghosting: same scan with 3-cycle dwell -> no acceptance, `frameValid` stays 0, errors stay 0.
- Bad pattern: strobe digit 1 with `segment`=8'b0111_1111 (a only) for 8 cycles -> `patErr`=1, no frame; `errClr` for 1 cycle -> `patErr`=0.
- Multi-digit: `digit`=8'b1111_1100 held for 8 cycles -> `multiErr`=1; `digit`=8'b1110_1111 -> `multiErr`=1.
- Timeout and reset: run with TIMEOUT=100; complete a frame -> `stale`=0, and `stale`=1 exactly 100 cycles after `frameValid`. Accept 2 digits, pulse `reset`, then accept the other 2 -> no `frameValid`.
- Dots: dp on for digit 2 only -> `dots`=4'b0100 with the macro defined, 4'b0000 without.
